feeder: RTL and testbench
=========================

FEEDER -- requirements
Module: feeder

Interface
REQ-001 Parameters: DATA_WIDTH, default 16, data word width; ADDR_WIDTH, default 16, address/counter width; DEPTH, default 1024, internal buffer words; BATCH_SIZE, default 1, images per run.
REQ-002 Clocking/reset SHALL be one clock; reset is asynchronous and active-low.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  asynchronous active-low reset.
REQ-005 valid_write  in  1  input word present this cycle.
REQ-006 start  in  1  enables loading; held high once started.
REQ-007 data_in  in  DATA_WIDTH  write data.
REQ-008 stride  in  2  convolution stride, 1..3.
REQ-009 chans_per_mem  in  ADDR_WIDTH  channel words per pixel, ≥1.
REQ-010 In_cols  in  ADDR_WIDTH  square input dimension.
REQ-011 k_dimension  in  ADDR_WIDTH  square kernel dimension.
REQ-012 o_dimension  in  ADDR_WIDTH  square output dimension.
REQ-013 data_out  out  DATA_WIDTH  streamed window word.
REQ-014 counter  out  ADDR_WIDTH  accepted-write count (write pointer).
REQ-015 state  out  2  FSM state.
REQ-016 wr_check  out  1  high in cycles a write is accepted.
REQ-017 last  out  8  current batch index during read.
REQ-018 ram_full  out  1  buffer load complete.
REQ-019 rd_idx  out  ADDR_WIDTH  current read address.
REQ-020 last_out  out  1  read stream finished.
REQ-021 loop_ctrl  out  8  {ky[3:0], kx[3:0]} of current read.

Function
REQ-022 States: IDLE=0, WRITE=1, READ=2, DONE=3.
REQ-023 IDLE->WRITE when start=1.
REQ-024 WRITE: write accepted when valid_write=1 and ram_full=0; data_in stored at address counter; counter+1; wr_check=1 that cycle, else 0.
REQ-025 TOTAL = In_cols*In_cols*chans_per_mem*BATCH_SIZE; ram_full SHALL assert the cycle after the TOTAL-th accepted write and stay high until reset; state->READ same cycle; writes ignored thereafter.
REQ-026 valid_write=0 in WRITE: no write, counter holds.
REQ-027 READ order, outermost to innermost: batch b, output row oy, output col ox, kernel row ky, kernel col kx, channel c; each index 0..limit-1; one read per cycle.
REQ-028 r=oy*stride+ky, q=ox*stride+kx; rd_idx = b*In_cols*In_cols*chans_per_mem + (r*In_cols+q)*chans_per_mem + c.
REQ-029 If r≥In_cols or q≥In_cols, data_out for that read SHALL be 0 (zero padding), no buffer access required.
REQ-030 Buffer synchronous; data_out valid one cycle after rd_idx is presented; data_out SHALL be 0 before first read result.
REQ-031 READ_LAST = k_dimension²*chans_per_mem*o_dimension²*BATCH_SIZE reads; after final data_out cycle, last_out=1, state=DONE, held until reset.
REQ-032 last = b, loop_ctrl = {ky,kx} of the address on rd_idx.
REQ-033 Index arithmetic ADDR_WIDTH unsigned; addresses ≥DEPTH wrap modulo DEPTH (caller keeps TOTAL≤DEPTH).
REQ-034 Configuration inputs SHALL be stable from start until DONE; changes mid-run are undefined.

Reset
REQ-035 rst=0 SHALL immediately force state=IDLE, counter=0, rd_idx=0, data_out=0, wr_check=0, ram_full=0, last_out=0, last=0, loop_ctrl=0, all loop indices 0; buffer contents need not clear.
REQ-036 Reset asserted mid-WRITE or mid-READ SHALL abort; after release a fresh load is required.

Verification
REQ-037 Reset: drive rst=0 with random inputs -> all outputs 0, state=0.
REQ-038 Load: In_cols=3, chans_per_mem=1, BATCH_SIZE=1, write 1..9 with one valid_write gap -> counter stalls at gap, ram_full=1 after 9th write, counter=9, state=2.
REQ-039 Full window: k=3, o=1, stride=1 after load -> data_out 1..9, then last_out=1, state=3.
REQ-040 Sliding: k=2, o=2, stride=1 -> 1,2,4,5, 2,3,5,6, 4,5,7,8, 5,6,8,9, then last_out.
REQ-041 Padding: k=3, o=3, stride=1 -> window ox=1 gives 2,3,0,5,6,0,8,9,0; total 81 outputs before last_out.
REQ-042 Channels/stride: In_cols=3, chans_per_mem=2, k=1, o=2, stride=2, words 1..18 -> 1,2,5,6,13,14,17,18; rst=0 mid-stream -> IDLE, outputs 0.

Source files
------------

// File: rtl/feeder.sv
// Convolution window feeder: loads an image into an internal buffer, then
// streams every kernel window (with zero padding) one word per cycle.
module feeder #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int DEPTH      = 1024,
    parameter int BATCH_SIZE = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_write,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [1:0]            stride,
    input  logic [ADDR_WIDTH-1:0] chans_per_mem,
    input  logic [ADDR_WIDTH-1:0] In_cols,
    input  logic [ADDR_WIDTH-1:0] k_dimension,
    input  logic [ADDR_WIDTH-1:0] o_dimension,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [ADDR_WIDTH-1:0] counter,
    output logic [1:0]            state,
    output logic                  wr_check,
    output logic [7:0]            last,
    output logic                  ram_full,
    output logic [ADDR_WIDTH-1:0] rd_idx,
    output logic                  last_out,
    output logic [7:0]            loop_ctrl
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] ONE   = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] BATCH = ADDR_WIDTH'(BATCH_SIZE);
    localparam logic [ADDR_WIDTH-1:0] BMAX  = ADDR_WIDTH'(BATCH_SIZE - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] b_q, oy_q, ox_q, ky_q, kx_q, c_q;
    logic                  pend_q;
    logic [ADDR_WIDTH-1:0] img_words, total, r, q, rd_addr;
    logic                  pad, wr_en, write_done, rd_last;

    function automatic logic [IW-1:0] wrap(input logic [ADDR_WIDTH-1:0] a);
        return IW'(32'(a) % DEPTH);
    endfunction

    always_comb begin
        img_words  = In_cols * In_cols * chans_per_mem;
        total      = img_words * BATCH;
        r          = oy_q * ADDR_WIDTH'(stride) + ky_q;
        q          = ox_q * ADDR_WIDTH'(stride) + kx_q;
        rd_addr    = b_q * img_words + (r * In_cols + q) * chans_per_mem + c_q;
        pad        = (r >= In_cols) || (q >= In_cols);
        wr_en      = (state_q == WRITE) && valid_write && !ram_full;
        write_done = wr_en && ((counter + ONE) == total);
        rd_last    = (c_q == chans_per_mem - ONE) && (kx_q == k_dimension - ONE) &&
                     (ky_q == k_dimension - ONE) && (ox_q == o_dimension - ONE) &&
                     (oy_q == o_dimension - ONE) && (b_q == BMAX);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = WRITE;
            WRITE:   if (write_done) state_d = READ;
            READ:    if (pend_q) state_d = DONE;
            default: state_d = DONE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wrap(counter)] <= data_in;
    end

    // pend_q marks the cycle carrying the final word; DONE follows it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            counter  <= '0;
            ram_full <= 1'b0;
            data_out <= '0;
            pend_q   <= 1'b0;
            last_out <= 1'b0;
            b_q      <= '0;
            oy_q     <= '0;
            ox_q     <= '0;
            ky_q     <= '0;
            kx_q     <= '0;
            c_q      <= '0;
        end else begin
            if (wr_en) begin
                counter <= counter + ONE;
                if (write_done) ram_full <= 1'b1;
            end
            if (state_q == READ && pend_q) last_out <= 1'b1;
            if (state_q == READ && !pend_q) begin
                data_out <= pad ? '0 : mem[wrap(rd_addr)];
                if (rd_last) begin
                    pend_q <= 1'b1;
                end else if (c_q != chans_per_mem - ONE) begin
                    c_q <= c_q + ONE;
                end else begin
                    c_q <= '0;
                    if (kx_q != k_dimension - ONE) begin
                        kx_q <= kx_q + ONE;
                    end else begin
                        kx_q <= '0;
                        if (ky_q != k_dimension - ONE) begin
                            ky_q <= ky_q + ONE;
                        end else begin
                            ky_q <= '0;
                            if (ox_q != o_dimension - ONE) begin
                                ox_q <= ox_q + ONE;
                            end else begin
                                ox_q <= '0;
                                if (oy_q != o_dimension - ONE) begin
                                    oy_q <= oy_q + ONE;
                                end else begin
                                    oy_q <= '0;
                                    b_q  <= b_q + ONE;
                                end
                            end
                        end
                    end
                end
            end
        end
    end

    assign state     = state_q;
    assign wr_check  = wr_en;
    assign rd_idx    = rd_addr;
    assign last      = 8'(b_q);
    assign loop_ctrl = {ky_q[3:0], kx_q[3:0]};

endmodule

// File: tb/tb_feeder.sv
// Self-checking bench for feeder: spec scenarios plus randomized configurations
// against a nested-loop reference model of the window stream.
module tb_feeder;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_write;
    logic        start;
    logic [15:0] data_in;
    logic [1:0]  stride;
    logic [15:0] chans_per_mem, In_cols, k_dimension, o_dimension;
    logic [15:0] data_out, counter, rd_idx;
    logic [1:0]  state;
    logic        wr_check, ram_full, last_out;
    logic [7:0]  last, loop_ctrl;

    int checks   = 0;
    int failures = 0;

    logic [15:0] words [1024];
    logic [15:0] obs [$];

    always #5 clk = ~clk;

    feeder #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .DEPTH(1024), .BATCH_SIZE(1)) dut (
        .clk(clk), .rst(rst), .valid_write(valid_write), .start(start),
        .data_in(data_in), .stride(stride), .chans_per_mem(chans_per_mem),
        .In_cols(In_cols), .k_dimension(k_dimension), .o_dimension(o_dimension),
        .data_out(data_out), .counter(counter), .state(state), .wr_check(wr_check),
        .last(last), .ram_full(ram_full), .rd_idx(rd_idx), .last_out(last_out),
        .loop_ctrl(loop_ctrl)
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        valid_write   = 1'($urandom);
        start         = 1'($urandom);
        data_in       = 16'($urandom);
        stride        = 2'($urandom_range(1, 3));
        chans_per_mem = 16'($urandom_range(1, 3));
        In_cols       = 16'($urandom_range(1, 5));
        k_dimension   = 16'($urandom_range(1, 3));
        o_dimension   = 16'($urandom_range(1, 3));
        rst = 1'b0;
        #2;
        checks++;
        if ({state, counter, rd_idx, data_out} !== '0) begin
            failures++;
            $display("FAIL reset_core got state=%0d counter=%0d rd_idx=%0d data_out=%0d want all 0",
                     state, counter, rd_idx, data_out);
        end
        checks++;
        if ({wr_check, ram_full, last_out, last, loop_ctrl} !== '0) begin
            failures++;
            $display("FAIL reset_flags got wr_check=%0b ram_full=%0b last_out=%0b last=%0d loop_ctrl=%0h want 0",
                     wr_check, ram_full, last_out, last, loop_ctrl);
        end
        tick();
        tick();
        checks++;
        if (state !== 2'd0 || counter !== 16'd0) begin
            failures++;
            $display("FAIL reset_hold got state=%0d counter=%0d want 0 0", state, counter);
        end
    endtask

    // Loads words 0..total-1, then checks the read stream; abort_at>=0 asserts reset
    // after that many stream samples.
    task automatic run_case(input string name, input int cols, input int cpm, input int k,
                            input int o, input int s, input bit rand_data,
                            input bit vw_in_read, input int abort_at);
        int total, accepted, cyc, n, r, q, addr;
        bit vw;
        logic [15:0] ex [$];
        logic [15:0] ea [$];
        logic [7:0]  el [$];
        obs.delete();
        total = cols * cols * cpm;

        @(negedge clk);
        rst = 1'b0; start = 1'b0; valid_write = 1'b0;
        In_cols = 16'(cols); chans_per_mem = 16'(cpm);
        k_dimension = 16'(k); o_dimension = 16'(o); stride = 2'(s);
        tick();
        rst = 1'b1;
        start = 1'b1;
        tick();
        checks++;
        if (state !== 2'd1) begin
            failures++;
            $display("FAIL %s enter_write got state=%0d want 1", name, state);
        end
        for (int i = 0; i < total; i++) words[i] = rand_data ? 16'($urandom) : 16'(i + 1);

        accepted = 0;
        cyc = 0;
        while (accepted < total && cyc < total * 8 + 20) begin
            vw = (cyc == 2) ? 1'b0 : ($urandom_range(0, 3) != 0);
            valid_write = vw;
            data_in = vw ? words[accepted] : 16'($urandom);
            #1;
            checks++;
            if (wr_check !== vw) begin
                failures++;
                $display("FAIL %s wr_check cyc=%0d got %0b want %0b", name, cyc, wr_check, vw);
            end
            tick();
            if (vw) accepted++;
            cyc++;
            checks++;
            if (counter !== 16'(accepted)) begin
                failures++;
                $display("FAIL %s counter cyc=%0d got %0d want %0d", name, cyc, counter, accepted);
            end
            if (accepted < total) begin
                checks++;
                if (state !== 2'd1 || ram_full !== 1'b0) begin
                    failures++;
                    $display("FAIL %s early_full got state=%0d ram_full=%0b want 1 0", name, state, ram_full);
                end
            end
        end
        checks++;
        if (accepted < total) begin
            failures++;
            $display("FAIL %s load_timeout got accepted=%0d want %0d", name, accepted, total);
            return;
        end
        valid_write = vw_in_read;
        data_in = 16'($urandom);
        checks++;
        if (ram_full !== 1'b1 || state !== 2'd2 || counter !== 16'(total)) begin
            failures++;
            $display("FAIL %s loaded got ram_full=%0b state=%0d counter=%0d want 1 2 %0d",
                     name, ram_full, state, counter, total);
        end

        for (int oy = 0; oy < o; oy++)
            for (int ox = 0; ox < o; ox++)
                for (int ky = 0; ky < k; ky++)
                    for (int kx = 0; kx < k; kx++)
                        for (int c = 0; c < cpm; c++) begin
                            r = oy * s + ky;
                            q = ox * s + kx;
                            addr = ((r * cols + q) * cpm + c) & 16'hFFFF;
                            ea.push_back(16'(addr));
                            el.push_back({4'(ky), 4'(kx)});
                            ex.push_back((r >= cols || q >= cols) ? 16'd0 : words[addr % 1024]);
                        end
        n = ex.size();

        for (int j = 0; j <= n; j++) begin
            if (j < n) begin
                checks++;
                if (rd_idx !== ea[j] || loop_ctrl !== el[j] || last !== 8'd0) begin
                    failures++;
                    $display("FAIL %s rd_addr j=%0d got rd_idx=%0d loop_ctrl=%0h last=%0d want %0d %0h 0",
                             name, j, rd_idx, loop_ctrl, last, ea[j], el[j]);
                end
            end
            checks++;
            if (j == 0) begin
                if (data_out !== 16'd0) begin
                    failures++;
                    $display("FAIL %s pre_read got data_out=%0d want 0", name, data_out);
                end
            end else begin
                obs.push_back(data_out);
                if (data_out !== ex[j-1] || last_out !== 1'b0) begin
                    failures++;
                    $display("FAIL %s stream j=%0d got data_out=%0d last_out=%0b want %0d 0",
                             name, j - 1, data_out, last_out, ex[j-1]);
                end
            end
            if (abort_at >= 0 && j == abort_at) begin
                #2;
                rst = 1'b0;
                #1;
                checks++;
                if ({state, counter, rd_idx, data_out, ram_full, last_out, last, loop_ctrl, wr_check} !== '0) begin
                    failures++;
                    $display("FAIL %s abort got state=%0d counter=%0d rd_idx=%0d data_out=%0d ram_full=%0b want 0",
                             name, state, counter, rd_idx, data_out, ram_full);
                end
                @(negedge clk);
                start = 1'b0;
                valid_write = 1'b0;
                rst = 1'b1;
                tick();
                checks++;
                if (state !== 2'd0 || data_out !== 16'd0) begin
                    failures++;
                    $display("FAIL %s post_abort_idle got state=%0d data_out=%0d want 0 0", name, state, data_out);
                end
                start = 1'b1;
                tick();
                checks++;
                if (state !== 2'd1 || counter !== 16'd0 || ram_full !== 1'b0) begin
                    failures++;
                    $display("FAIL %s fresh_load got state=%0d counter=%0d ram_full=%0b want 1 0 0",
                             name, state, counter, ram_full);
                end
                return;
            end
            tick();
        end
        checks++;
        if (last_out !== 1'b1 || state !== 2'd3) begin
            failures++;
            $display("FAIL %s finish got last_out=%0b state=%0d want 1 3", name, last_out, state);
        end
        tick();
        tick();
        checks++;
        if (last_out !== 1'b1 || state !== 2'd3 || counter !== 16'(total) || wr_check !== 1'b0) begin
            failures++;
            $display("FAIL %s done_hold got last_out=%0b state=%0d counter=%0d wr_check=%0b want 1 3 %0d 0",
                     name, last_out, state, counter, wr_check, total);
        end
        valid_write = 1'b0;
    endtask

    task automatic test_full_window();
        run_case("full_window", 3, 1, 3, 1, 1, 1'b0, 1'b1, -1);
        checks++;
        if (obs.size() != 9 || obs[0] !== 16'd1 || obs[8] !== 16'd9) begin
            failures++;
            $display("FAIL full_window count got %0d outputs want 9 (1..9)", obs.size());
        end
    endtask

    task automatic test_sliding();
        logic [15:0] want [16] = '{1,2,4,5, 2,3,5,6, 4,5,7,8, 5,6,8,9};
        run_case("sliding", 3, 1, 2, 2, 1, 1'b0, 1'b0, -1);
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (i >= obs.size() || obs[i] !== want[i]) begin
                failures++;
                $display("FAIL sliding word %0d got %0d want %0d", i, (i < obs.size()) ? obs[i] : 16'hxxxx, want[i]);
            end
        end
    endtask

    task automatic test_padding();
        logic [15:0] want [9] = '{2,3,0, 5,6,0, 8,9,0};
        run_case("padding", 3, 1, 3, 3, 1, 1'b0, 1'b0, -1);
        checks++;
        if (obs.size() != 81) begin
            failures++;
            $display("FAIL padding count got %0d want 81", obs.size());
        end
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (9 + i >= obs.size() || obs[9 + i] !== want[i]) begin
                failures++;
                $display("FAIL padding ox1 word %0d got %0d want %0d", i,
                         (9 + i < obs.size()) ? obs[9 + i] : 16'hxxxx, want[i]);
            end
        end
    endtask

    task automatic test_channels_stride();
        logic [15:0] want [8] = '{1,2,5,6,13,14,17,18};
        run_case("chan_stride", 3, 2, 1, 2, 2, 1'b0, 1'b0, -1);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (i >= obs.size() || obs[i] !== want[i]) begin
                failures++;
                $display("FAIL chan_stride word %0d got %0d want %0d", i, (i < obs.size()) ? obs[i] : 16'hxxxx, want[i]);
            end
        end
        run_case("abort", 3, 2, 1, 2, 2, 1'b0, 1'b0, 4);
    endtask

    task automatic test_random();
        for (int t = 0; t < 6; t++)
            run_case("random", $urandom_range(1, 5), $urandom_range(1, 3), $urandom_range(1, 3),
                     $urandom_range(1, 3), $urandom_range(1, 3), 1'b1, 1'($urandom), -1);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; valid_write = 1'b0; data_in = '0;
        stride = 2'd1; chans_per_mem = 16'd1; In_cols = 16'd3;
        k_dimension = 16'd1; o_dimension = 16'd1;
        test_reset();
        test_full_window();
        test_sliding();
        test_padding();
        test_channels_stride();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
